step_fetch_unit: RTL and testbench
==================================

STEP_FETCH_UNIT -- requirements
Module: step_fetch_unit

Interface
REQ-001 SHALL have parameters: DIV, default 25000000, clk_in cycles per tick; DEPTH, default 3000, instruction memory words; ADDR_W, default 32, PC width; DATA_W, default 32, instruction width.
REQ-002 SHALL have ports, one per line:
- clk_in  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- step_mode  in  1  1 = single-step, 0 = free-run on tick.
- step_req  in  1  single-step request, edge-detected.
- halt  in  1  blocks new fetches.
- redir_valid  in  1  redirect request.
- redir_pc  in  ADDR_W  redirect target byte address.
- redir_ready  out  1  redirect accepted this cycle.
- mem_addr  out  ADDR_W  word index (pc>>2).
- mem_rd  out  1  read strobe.
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_rd.
- ir  out  DATA_W  last fetched instruction.
- ir_valid  out  1  one-cycle pulse on ir update.
- pc  out  ADDR_W  byte address of next fetch.
- tick  out  1  one-cycle divider pulse.
- heartbeat  out  1  toggles per fetch.
- fault  out  1  sticky fault.
- lui_seen  out  1  sticky LUI-opcode flag.

Function
REQ-003 Divider SHALL count 0..DIV-1 and wrap; tick SHALL be 1 in the cycle the count equals DIV-1, every DIV cycles, in both modes.
REQ-004 FSM states SHALL be IDLE, READ, LATCH, FAULT.
REQ-005 IDLE->READ SHALL occur when halt=0, fault=0 and a trigger is present: tick when step_mode=0; a rising edge of step_req when step_mode=1.
REQ-006 step_req edge detection SHALL use one registered copy; rising edges while not in IDLE SHALL be dropped, not queued.
REQ-007 READ SHALL assert mem_rd for exactly one cycle with mem_addr=pc>>2, then go to LATCH.
REQ-008 LATCH SHALL load ir<=mem_rdata, pulse ir_valid, toggle heartbeat, set pc<=pc+4 (modulo 2^ADDR_W), and return to IDLE; fetch latency is 2 cycles from trigger.
REQ-009 redir_ready SHALL be 1 only in IDLE with redir_valid=1; redir_ready combinationally tracks redir_valid within IDLE.
REQ-010 On accepted redirect, pc<=redir_pc; redirect takes priority over a simultaneous trigger, which is dropped.
REQ-011 Redirect with redir_pc[1:0]!=0 SHALL be accepted, leave pc unchanged, and enter FAULT.
REQ-012 A trigger with (pc>>2)>=DEPTH SHALL enter FAULT without asserting mem_rd.
REQ-013 FAULT SHALL be terminal until reset: fault=1, mem_rd=0, redir_ready=0, ir/pc frozen.
REQ-014 halt asserted during READ/LATCH SHALL NOT abort the fetch in progress; it blocks only IDLE->READ.
REQ-015 Changing step_mode SHALL take effect at the next IDLE decision.

Reset
REQ-016 reset=1 SHALL immediately force: state IDLE, divider 0, pc 0, ir 0, ir_valid 0, mem_rd 0, redir_ready 0, tick 0, heartbeat 0, fault 0, lui_seen 0, step_req history 0.
REQ-017 Reset mid-fetch SHALL discard the fetch; no ir_valid SHALL follow release.

Configuration
REQ-018 Macro STEP_FETCH_DECODE_EN: when defined, lui_seen SHALL set in LATCH when mem_rdata[6:0]==7'b0110111 and hold until reset; when undefined, lui_seen SHALL be tied 0 and no decode logic built.

Verification (DIV=4, DEPTH=8)
REQ-019 Free-run, mem[i]=i: ir_valid every 4 cycles, ir=0,1,2...,7; pc 0,4,...,32; 9th tick -> fault=1, no mem_rd.
REQ-020 step_mode=1, step_req held high 20 cycles -> exactly one fetch, ir=mem[0], pc=4.
REQ-021 redir_valid with redir_pc=0x14 in IDLE coincident with tick -> redir_ready=1, tick dropped, next fetch reads mem_addr=5.
REQ-022 redir_pc=0x6 -> fault=1, pc unchanged, all later triggers ignored.
REQ-023 halt=1 in READ cycle -> fetch completes with ir_valid; subsequent ticks produce no mem_rd until halt=0.
REQ-024 mem[0]=0x000000B7, reset pulse asserted in LATCH-cycle of a second run -> all outputs 0 immediately; with STEP_FETCH_DECODE_EN lui_seen=1 after first fetch, 0 without.

Source files
------------

// File: rtl/step_fetch_unit.sv
// step_fetch_unit: tick-paced / single-step instruction fetch unit.
// Fetches one word per trigger from a synchronous instruction memory,
// holding it in ir, with redirect support and a terminal fault state.
//
// Build option:
//   STEP_FETCH_DECODE_EN  when defined, lui_seen latches on a fetched LUI
//                         opcode; when undefined lui_seen is tied low.
//
// Ports:
//   clk_in       sole clock
//   reset        asynchronous active-high reset
//   step_mode    1 = single-step on step_req rising edge, 0 = free-run on tick
//   step_req     single-step request (edge-detected)
//   halt         blocks new fetches (never aborts one in flight)
//   redir_valid  redirect request
//   redir_pc     redirect target byte address
//   redir_ready  redirect accepted this cycle (combinational, IDLE only)
//   mem_addr     memory word index (pc >> 2)
//   mem_rd       memory read strobe, one cycle per fetch
//   mem_rdata    memory read data, valid the cycle after mem_rd
//   ir           last fetched instruction
//   ir_valid     one-cycle pulse when ir updates
//   pc           byte address of the next fetch
//   tick         one-cycle divider pulse every DIV cycles
//   heartbeat    toggles once per completed fetch
//   fault        sticky fault indicator
//   lui_seen     sticky LUI-opcode flag
module step_fetch_unit #(
  parameter int unsigned DIV    = 25000000,
  parameter int unsigned DEPTH  = 3000,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              halt,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              redir_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              tick,
  output logic              heartbeat,
  output logic              fault,
  output logic              lui_seen
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  cnt;
  logic              step_req_q;
  logic              trigger;
  logic              out_of_range;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] ir_next;
  logic              ir_valid_next;
  logic              heartbeat_next;

  // Free-running tick divider, independent of mode and FSM state
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

  // A step_req edge is only seen for one cycle, so edges arriving outside IDLE are lost
  assign trigger      = step_mode ? (step_req & ~step_req_q) : tick;
  assign mem_addr     = {2'b00, pc[ADDR_W-1:2]};
  assign out_of_range = (mem_addr >= ADDR_W'(DEPTH));

  // State and registered outputs
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      ir         <= '0;
      ir_valid   <= 1'b0;
      mem_rd     <= 1'b0;
      heartbeat  <= 1'b0;
      fault      <= 1'b0;
      step_req_q <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ir         <= ir_next;
      ir_valid   <= ir_valid_next;
      mem_rd     <= (state_next == READ);
      heartbeat  <= heartbeat_next;
      fault      <= (state_next == FAULT);
      step_req_q <= step_req;
    end
  end

  // Next-state and datapath decisions; a redirect beats a same-cycle trigger
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    ir_next        = ir;
    ir_valid_next  = 1'b0;
    heartbeat_next = heartbeat;
    redir_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (redir_valid) begin
          redir_ready = ~reset;
          if (redir_pc[1:0] != 2'b00) begin
            state_next = FAULT;
          end else begin
            pc_next = redir_pc;
          end
        end else if (trigger && !halt) begin
          state_next = out_of_range ? FAULT : READ;
        end
      end
      READ: begin
        state_next = LATCH;
      end
      LATCH: begin
        ir_next        = mem_rdata;
        ir_valid_next  = 1'b1;
        heartbeat_next = ~heartbeat;
        pc_next        = pc + ADDR_W'(4);
        state_next     = IDLE;
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef STEP_FETCH_DECODE_EN
  // Sticky flag: any fetched word carrying the LUI opcode
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      lui_seen <= 1'b0;
    end else if ((state == LATCH) && (mem_rdata[6:0] == OPC_LUI)) begin
      lui_seen <= 1'b1;
    end
  end
`else
  logic [6:0] opc_unused;
  assign opc_unused = OPC_LUI;
  assign lui_seen   = 1'b0;
`endif

endmodule

// File: tb/tb_step_fetch_unit.sv
// tb_step_fetch_unit: directed self-checking bench for step_fetch_unit
// (DIV=4, DEPTH=8) with a one-cycle-latency instruction memory model.
module tb_step_fetch_unit;

  localparam int unsigned DIV    = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

`ifdef STEP_FETCH_DECODE_EN
  localparam logic LUI_EXP = 1'b1;
`else
  localparam logic LUI_EXP = 1'b0;
`endif

  logic              clk_in;
  logic              reset;
  logic              step_mode;
  logic              step_req;
  logic              halt;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              redir_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic [ADDR_W-1:0] pc;
  logic              tick;
  logic              heartbeat;
  logic              fault;
  logic              lui_seen;

  logic [DATA_W-1:0] mem [DEPTH];

  int vectors     = 0;
  int miscompares = 0;

  step_fetch_unit #(
    .DIV(DIV), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk_in(clk_in), .reset(reset), .step_mode(step_mode), .step_req(step_req),
    .halt(halt), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid), .pc(pc), .tick(tick),
    .heartbeat(heartbeat), .fault(fault), .lui_seen(lui_seen)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Synchronous memory: data appears the cycle after the read strobe
  always @(posedge clk_in) begin
    if (mem_rd) begin
      mem_rdata <= (mem_addr < DEPTH) ? mem[mem_addr[2:0]] : 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_rd(input int budget, output logic seen, output int cycles);
    seen = 1'b0; cycles = 0;
    while (!seen && cycles < budget) begin step(); cycles++; seen = mem_rd; end
  endtask

  task automatic wait_ir(input int budget, output logic seen, output int cycles);
    seen = 1'b0; cycles = 0;
    while (!seen && cycles < budget) begin step(); cycles++; seen = ir_valid; end
  endtask

  task automatic wait_tick(input int budget, output logic seen);
    int cycles;
    seen = 1'b0; cycles = 0;
    while (!seen && cycles < budget) begin step(); cycles++; seen = tick; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic seen;
    int   c_rd;
    int   c_ir;
    int   n_rd;
    int   n_ir;

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'(i);
    mem_rdata   = '0;
    reset       = 1'b1;
    step_mode   = 1'b0;
    step_req    = 1'b0;
    halt        = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;

    // Reset state
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_heartbeat", 32'(heartbeat), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_lui_seen", 32'(lui_seen), 32'h0);
    redir_valid = 1'b1;
    #1;
    chk("rst_redir_ready", 32'(redir_ready), 32'h0);
    redir_valid = 1'b0;

    // Free-run over the whole memory, then out-of-range fault
    reset = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      wait_rd(12, seen, c_rd);
      chk("fr_rd_seen", 32'(seen), 32'h1);
      chk("fr_mem_addr", mem_addr, 32'(i));
      wait_ir(4, seen, c_ir);
      chk("fr_ir_seen", 32'(seen), 32'h1);
      chk("fr_ir", ir, 32'(i));
      chk("fr_pc", pc, 32'(4 * (i + 1)));
      chk("fr_heartbeat", 32'(heartbeat), 32'((i + 1) % 2));
      if (i > 0) chk("fr_gap", 32'(c_rd + c_ir), 32'(DIV));
    end
    n_rd = 0;
    for (int k = 0; k < 8; k++) begin step(); if (mem_rd) n_rd++; end
    chk("oor_fault", 32'(fault), 32'h1);
    chk("oor_no_rd", 32'(n_rd), 32'h0);
    chk("oor_pc", pc, 32'h20);
    chk("oor_ir", ir, 32'h7);
    redir_valid = 1'b1;
    redir_pc    = 32'h0;
    #1;
    chk("fault_redir_ready", 32'(redir_ready), 32'h0);
    redir_valid = 1'b0;
    step();
    chk("fault_pc_frozen", pc, 32'h20);

    // Single-step: held request yields exactly one fetch
    mem[0]    = 32'hA5A5_0013;
    step_mode = 1'b1;
    do_reset();
    step();
    step_req = 1'b1;
    step();
    chk("ss_rd", 32'(mem_rd), 32'h1);
    chk("ss_addr", mem_addr, 32'h0);
    step();
    chk("ss_latch_rd", 32'(mem_rd), 32'h0);
    step();
    chk("ss_ir_valid", 32'(ir_valid), 32'h1);
    chk("ss_ir", ir, mem[0]);
    chk("ss_pc", pc, 32'h4);
    n_rd = 0; n_ir = 0;
    for (int k = 0; k < 17; k++) begin
      step();
      if (mem_rd) n_rd++;
      if (ir_valid) n_ir++;
    end
    chk("ss_held_rd", 32'(n_rd), 32'h0);
    chk("ss_held_ir", 32'(n_ir), 32'h0);
    step_req = 1'b0;
    step();
    step_req = 1'b1;
    wait_ir(6, seen, c_ir);
    chk("ss2_seen", 32'(seen), 32'h1);
    chk("ss2_ir", ir, mem[1]);
    chk("ss2_pc", pc, 32'h8);
    step_req = 1'b0;

    // Redirect coincident with tick wins; the tick is dropped
    step_mode = 1'b0;
    do_reset();
    wait_tick(8, seen);
    chk("rd_tick_seen", 32'(seen), 32'h1);
    redir_valid = 1'b1;
    redir_pc    = 32'h14;
    #1;
    chk("rd_ready", 32'(redir_ready), 32'h1);
    step();
    redir_valid = 1'b0;
    chk("rd_tick_dropped", 32'(mem_rd), 32'h0);
    chk("rd_pc", pc, 32'h14);
    wait_rd(8, seen, c_rd);
    chk("rd_rd_seen", 32'(seen), 32'h1);
    chk("rd_mem_addr", mem_addr, 32'h5);
    redir_valid = 1'b1;
    redir_pc    = 32'h0;
    #1;
    chk("rd_ready_busy", 32'(redir_ready), 32'h0);
    redir_valid = 1'b0;
    wait_ir(4, seen, c_ir);
    chk("rd_ir", ir, 32'h5);
    chk("rd_pc_after", pc, 32'h18);

    // Misaligned redirect: accepted, pc kept, terminal fault
    redir_valid = 1'b1;
    redir_pc    = 32'h6;
    #1;
    chk("mis_ready", 32'(redir_ready), 32'h1);
    step();
    redir_valid = 1'b0;
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_pc", pc, 32'h18);
    n_rd = 0; n_ir = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (mem_rd) n_rd++;
      if (ir_valid) n_ir++;
    end
    chk("mis_no_rd", 32'(n_rd), 32'h0);
    chk("mis_no_ir", 32'(n_ir), 32'h0);
    chk("mis_ir_frozen", ir, 32'h5);

    // Halt raised during READ completes that fetch, blocks later ones
    do_reset();
    wait_rd(12, seen, c_rd);
    chk("halt_rd_seen", 32'(seen), 32'h1);
    halt = 1'b1;
    wait_ir(4, seen, c_ir);
    chk("halt_ir_seen", 32'(seen), 32'h1);
    chk("halt_ir", ir, mem[0]);
    chk("halt_pc", pc, 32'h4);
    n_rd = 0;
    for (int k = 0; k < 12; k++) begin step(); if (mem_rd) n_rd++; end
    chk("halt_blocked", 32'(n_rd), 32'h0);
    halt = 1'b0;
    wait_rd(8, seen, c_rd);
    chk("unhalt_rd_seen", 32'(seen), 32'h1);
    chk("unhalt_addr", mem_addr, 32'h1);

    // LUI decode, then reset in the LATCH cycle of the second fetch
    mem[0] = 32'h0000_00B7;
    do_reset();
    wait_ir(12, seen, c_ir);
    chk("lui_ir", ir, 32'hB7);
    chk("lui_seen", 32'(lui_seen), 32'(LUI_EXP));
    wait_rd(8, seen, c_rd);
    chk("lat_rd_seen", 32'(seen), 32'h1);
    step();
    redir_valid = 1'b1;
    reset       = 1'b1;
    #1;
    chk("mid_pc", pc, 32'h0);
    chk("mid_ir", ir, 32'h0);
    chk("mid_heartbeat", 32'(heartbeat), 32'h0);
    chk("mid_lui_seen", 32'(lui_seen), 32'h0);
    chk("mid_mem_rd", 32'(mem_rd), 32'h0);
    chk("mid_ir_valid", 32'(ir_valid), 32'h0);
    chk("mid_tick", 32'(tick), 32'h0);
    chk("mid_redir_ready", 32'(redir_ready), 32'h0);
    redir_valid = 1'b0;
    step_mode   = 1'b1;
    step();
    reset = 1'b0;
    n_rd = 0; n_ir = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (mem_rd) n_rd++;
      if (ir_valid) n_ir++;
    end
    chk("post_rst_no_ir", 32'(n_ir), 32'h0);
    chk("post_rst_no_rd", 32'(n_rd), 32'h0);
    chk("post_rst_pc", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
